pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the fetch stage of the MIPS datapath. Holds the architectural PC and selects the next PC each cycle from sequential PC+4, a taken branch, a J/JAL jump target, or a JR register target. Forms the jump target by concatenating the upper nibble of the jumping instruction's PC+4 with the shifted 26-bit index. Also generates the IF/ID flush, a fetch-valid qualifier, a sticky JR-misalignment flag, and a saturating redirect counter.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  hazard stall; freezes PC and blocks redirects.
- BranchTaken  in  1  ID-stage branch resolved taken.
- BranchTarget  in  32  branch target address.
- Jump  in  1  ID-stage J/JAL.
- JumpIndex  in  26  instr[25:0] of the jump.
- IdPCPlus4  in  32  PC+4 of the instruction in ID.
- JumpReg  in  1  ID-stage JR.
- RegTarget  in  32  rs value for JR.
- PC  out  32  current fetch address (registered).
- PCPlus4  out  32  PC + 4 (combinational from PC).
- FetchValid  out  1  IF instruction is valid (registered).
- Flush  out  1  kill the instruction entering IF/ID this cycle.
- AlignErr  out  1  sticky: JR target had nonzero [1:0].
- RedirectCount  out  16  accepted redirects, saturating.

## Operation
- States: BOOT, RUN.
  - Reset forces BOOT.
  - BOOT → RUN after one cycle with Reset=0.
  - RUN has no exit except Reset.
- BOOT behaviour:
  - PC holds RESET_PC.
  - FetchValid=0, Flush=0.
  - All redirect inputs ignored.
- RUN, Stall=1:
  - PC holds.
  - Flush=0.
  - Redirect inputs ignored; the stalled ID instruction re-presents them.
- RUN, Stall=0, redirect priority (single winner, others ignored):
  1. JumpReg: target = {RegTarget[31:2], 2'b00}. If RegTarget[1:0]≠0, set AlignErr.
  2. Jump: target = {IdPCPlus4[31:28], JumpIndex, 2'b00}.
  3. BranchTaken: target = {BranchTarget[31:2], 2'b00}.
- Accepted redirect:
  - PC ← target on the next edge.
  - Flush=1 during the acceptance cycle.
  - RedirectCount increments, saturating at 16'hFFFF.
- RUN, Stall=0, no redirect: PC ← PC+4.
- Arithmetic: all 32-bit modulo. PCPlus4 at 32'hFFFF_FFFC is 32'h0000_0000, and PC wraps the same way.
- PC[1:0] is always 2'b00.

## Timing
- Reset values (edge with Reset=1):
  - PC = RESET_PC, PCPlus4 = RESET_PC+4.
  - FetchValid = 0, AlignErr = 0, RedirectCount = 0, state BOOT.
  - Flush = 0 while Reset=1.
- Reset asserted mid-operation overrides everything on that edge, including a simultaneous redirect or Stall.
- First Reset=0 cycle is BOOT. FetchValid rises at the following edge (state enters RUN). The PC first advances on the edge ending the first RUN cycle.
- Flush is combinational: Flush = (state==RUN) & ~Stall & (JumpReg | Jump | BranchTaken). It is valid in the same cycle as the inputs.
- Redirect latency: the target appears on PC one edge after acceptance. No delay slot; the wrong-path IF instruction is the one flushed.
- Back-to-back redirects on consecutive unstalled cycles are each accepted and each counted.
- AlignErr sets on the edge ending the accepting cycle and clears only on Reset.

## Test plan
- Reset/boot with RESET_PC=32'h0000_0100: hold Reset 2 cycles, release. Required:
  - PC=0x100 and FetchValid=0 through the BOOT cycle.
  - FetchValid=1 at the next edge.
  - PC=0x104 one edge later.
- Jump target formation: in RUN, Jump=1, JumpIndex=26'h000_0040, IdPCPlus4=32'h3000_0008. Required:
  - Flush=1 that cycle.
  - Next PC=32'h3000_0100.
  - RedirectCount=1.
- Priority: JumpReg=1, RegTarget=32'h0000_2002, Jump=1, BranchTaken=1, same cycle. Required:
  - Next PC=32'h0000_2000.
  - AlignErr=1 and stays 1 until Reset.
  - RedirectCount increments by 1.
- Stall masking: Stall=1 with BranchTaken=1, BranchTarget=0x400 for 3 cycles, then Stall=0. Required:
  - PC frozen for 3 cycles, Flush=0.
  - Redirect to 0x400 accepted only on the unstalled cycle, with a single count.
- Wrap and saturation:
  - PC reaches 32'hFFFF_FFFC. Required: PCPlus4=0 and next PC=0.
  - Preload 65535 redirects, then apply one more. Required: RedirectCount stays 16'hFFFF.
- Reset mid-redirect: Reset=1 together with Jump=1. Required: PC=RESET_PC, Flush=0, RedirectCount=0, state BOOT.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: holds the PC, picks the next PC from
// sequential, branch, jump or register targets, and reports flush/valid/status.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [25:0] JumpIndex,
    input  logic [31:0] IdPCPlus4,
    input  logic        JumpReg,
    input  logic [31:0] RegTarget,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        FetchValid,
    output logic        Flush,
    output logic        AlignErr,
    output logic [15:0] RedirectCount
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    logic        redirect;
    logic [31:0] target;

    assign PCPlus4  = PC + 32'd4;
    assign redirect = JumpReg | Jump | BranchTaken;

    // Flush is qualified by Reset as well so a reset landing in RUN never kills IF.
    assign Flush = (state == RUN) & ~Stall & ~Reset & redirect;

    always_comb begin
        target = PCPlus4;
        if (JumpReg) begin
            target = {RegTarget[31:2], 2'b00};
        end else if (Jump) begin
            target = {IdPCPlus4[31:28], JumpIndex, 2'b00};
        end else if (BranchTaken) begin
            target = {BranchTarget[31:2], 2'b00};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= BOOT;
            PC            <= {RESET_PC[31:2], 2'b00};
            FetchValid    <= 1'b0;
            AlignErr      <= 1'b0;
            RedirectCount <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state      <= RUN;
                    FetchValid <= 1'b1;
                end
                RUN: begin
                    if (!Stall) begin
                        PC <= target;
                        if (redirect && (RedirectCount != '1)) begin
                            RedirectCount <= RedirectCount + 16'd1;
                        end
                        if (JumpReg && (RegTarget[1:0] != 2'b00)) begin
                            AlignErr <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= BOOT;
                    FetchValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: behavioural model compared every cycle,
// directed scenarios with literal expectations, and randomized traffic.
module tb_pc_sequencer;

    localparam logic [31:0] RST = 32'h0000_0100;

    logic        Clk = 1'b0;
    logic        Reset, Stall, BranchTaken, Jump, JumpReg;
    logic [31:0] BranchTarget, IdPCPlus4, RegTarget;
    logic [25:0] JumpIndex;
    logic [31:0] PC, PCPlus4;
    logic        FetchValid, Flush, AlignErr;
    logic [15:0] RedirectCount;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    // reference model state
    bit          m_valid = 0;
    bit          m_run;
    bit          m_ae;
    logic [31:0] m_pc;
    int unsigned m_cnt;

    pc_sequencer #(.RESET_PC(RST)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Jump(Jump), .JumpIndex(JumpIndex), .IdPCPlus4(IdPCPlus4),
        .JumpReg(JumpReg), .RegTarget(RegTarget),
        .PC(PC), .PCPlus4(PCPlus4), .FetchValid(FetchValid), .Flush(Flush),
        .AlignErr(AlignErr), .RedirectCount(RedirectCount)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    always @(posedge Clk) begin
        if (Reset) begin
            m_valid = 1;
            m_run   = 0;
            m_ae    = 0;
            m_cnt   = 0;
            m_pc    = RST;
        end else if (m_valid) begin
            if (!m_run) begin
                m_run = 1;
            end else if (!Stall) begin
                if (JumpReg) begin
                    m_pc = (RegTarget / 4) * 4;
                    if (RegTarget % 4 != 0) m_ae = 1;
                end else if (Jump) begin
                    m_pc = (IdPCPlus4 & 32'hF000_0000) + {4'h0, JumpIndex, 2'b00};
                end else if (BranchTaken) begin
                    m_pc = (BranchTarget / 4) * 4;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
                if ((JumpReg || Jump || BranchTaken) && m_cnt < 65535) m_cnt++;
            end
        end
    end

    always @(negedge Clk) begin
        if (m_valid) begin
            check("pc", PC, m_pc);
            check("pcplus4", PCPlus4, m_pc + 32'd4);
            check("fetchvalid", {31'd0, FetchValid}, {31'd0, m_run});
            check("flush", {31'd0, Flush},
                  {31'd0, m_run && !Stall && !Reset && (JumpReg || Jump || BranchTaken)});
            check("alignerr", {31'd0, AlignErr}, {31'd0, m_ae});
            check("redirectcount", {16'd0, RedirectCount}, m_cnt);
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic clear_redirects();
        BranchTaken = 0; Jump = 0; JumpReg = 0; Stall = 0;
    endtask

    logic [31:0] held_pc;

    initial begin
        Reset = 1; Stall = 0; BranchTaken = 0; Jump = 0; JumpReg = 0;
        BranchTarget = '0; IdPCPlus4 = '0; RegTarget = '0; JumpIndex = '0;

        // reset and boot
        step(2);
        check("rst_pc", PC, 32'h0000_0100);
        check("rst_pcplus4", PCPlus4, 32'h0000_0104);
        check("rst_fv", {31'd0, FetchValid}, 32'd0);
        check("rst_cnt", {16'd0, RedirectCount}, 32'd0);
        Reset = 0;
        @(negedge Clk);
        check("boot_pc", PC, 32'h0000_0100);
        check("boot_fv", {31'd0, FetchValid}, 32'd0);
        step(1);
        check("run_fv", {31'd0, FetchValid}, 32'd1);
        check("run_pc_held", PC, 32'h0000_0100);
        step(1);
        check("first_adv", PC, 32'h0000_0104);

        // jump target formation
        Jump = 1; JumpIndex = 26'h000_0040; IdPCPlus4 = 32'h3000_0008;
        @(negedge Clk);
        check("jump_flush", {31'd0, Flush}, 32'd1);
        step(1);
        check("jump_pc", PC, 32'h3000_0100);
        check("jump_cnt", {16'd0, RedirectCount}, 32'd1);
        clear_redirects();

        // priority: JR wins, misaligned target sets AlignErr
        JumpReg = 1; RegTarget = 32'h0000_2002; Jump = 1; BranchTaken = 1;
        BranchTarget = 32'h0000_9000;
        step(1);
        check("prio_pc", PC, 32'h0000_2000);
        check("prio_ae", {31'd0, AlignErr}, 32'd1);
        check("prio_cnt", {16'd0, RedirectCount}, 32'd2);
        clear_redirects();

        // stall masking
        held_pc = PC;
        Stall = 1; BranchTaken = 1; BranchTarget = 32'h0000_0400;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("stall_flush", {31'd0, Flush}, 32'd0);
            step(1);
            check("stall_pc", PC, held_pc);
        end
        Stall = 0;
        @(negedge Clk);
        check("unstall_flush", {31'd0, Flush}, 32'd1);
        step(1);
        check("unstall_pc", PC, 32'h0000_0400);
        check("unstall_cnt", {16'd0, RedirectCount}, 32'd3);
        clear_redirects();
        step(1);
        check("seq_pc", PC, 32'h0000_0404);
        check("ae_sticky", {31'd0, AlignErr}, 32'd1);

        // wrap at top of address space
        JumpReg = 1; RegTarget = 32'hFFFF_FFFC;
        step(1);
        clear_redirects();
        check("wrap_pc", PC, 32'hFFFF_FFFC);
        check("wrap_pcplus4", PCPlus4, 32'h0000_0000);
        step(1);
        check("wrap_next", PC, 32'h0000_0000);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            Reset        = ($urandom_range(0, 199) == 0);
            Stall        = ($urandom_range(0, 3) == 0);
            JumpReg      = ($urandom_range(0, 7) == 0);
            Jump         = ($urandom_range(0, 5) == 0);
            BranchTaken  = ($urandom_range(0, 4) == 0);
            RegTarget    = $urandom;
            BranchTarget = $urandom;
            IdPCPlus4    = $urandom;
            JumpIndex    = 26'($urandom);
            step(1);
        end
        Reset = 0;
        clear_redirects();

        // saturation of the redirect counter
        Reset = 1;
        step(1);
        Reset = 0;
        step(2);
        BranchTaken = 1; BranchTarget = 32'h0000_1000;
        step(65535);
        check("sat_reach", {16'd0, RedirectCount}, 32'h0000_FFFF);
        step(3);
        check("sat_hold", {16'd0, RedirectCount}, 32'h0000_FFFF);
        clear_redirects();
        step(2);

        // reset during a redirect
        Jump = 1; JumpIndex = 26'h3FF_FFFF; IdPCPlus4 = 32'h5000_0000; Reset = 1;
        @(negedge Clk);
        check("rstmid_flush", {31'd0, Flush}, 32'd0);
        step(1);
        check("rstmid_pc", PC, RST);
        check("rstmid_cnt", {16'd0, RedirectCount}, 32'd0);
        check("rstmid_fv", {31'd0, FetchValid}, 32'd0);
        check("rstmid_ae", {31'd0, AlignErr}, 32'd0);
        Reset = 0;
        @(negedge Clk);
        check("boot_ignore_flush", {31'd0, Flush}, 32'd0);
        step(1);
        check("boot_ignore_pc", PC, RST);
        check("boot_ignore_cnt", {16'd0, RedirectCount}, 32'd0);
        clear_redirects();
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
